// File: rtl/wb_stage_if.sv
// Bus bundle for the MIPS writeback stage: MEM-side inputs, SRAM read data,
// stall/flush control, and the regfile, forwarding and retire outputs.
interface wb_stage_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          stall;
  logic          flush;
  logic          mem_valid;
  logic [31:0]   mem_pc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_result;
  logic [2:0]    mem_load_op;
  logic [DW-1:0] data_sram_rdata;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          fwd_valid;
  logic [AW-1:0] fwd_waddr;
  logic [DW-1:0] fwd_wdata;
  logic          wb_valid;
  logic [31:0]   wb_pc;
  logic [31:0]   retire_cnt;

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_we, mem_waddr, mem_result,
           mem_load_op, data_sram_rdata,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_waddr, fwd_wdata,
           wb_valid, wb_pc, retire_cnt
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_we, mem_waddr, mem_result,
           mem_load_op, data_sram_rdata,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_waddr, fwd_wdata,
           wb_valid, wb_pc, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, load extraction, single-shot regfile write.
// Define WB_TRACE_EN to add the debug_wb_* trace outputs.
module wb_stage #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   bus
`ifdef WB_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

  logic          r_wb_valid;
  logic [31:0]   r_wb_pc;
  logic          r_wb_we;
  logic [AW-1:0] r_wb_waddr;
  logic [DW-1:0] r_wb_result;
  logic [2:0]    r_wb_load_op;
  logic          r_done;
  logic [DW-1:0] r_wdata_hold;
  logic [31:0]   r_retire_cnt;

  logic          w_commit;
  logic [DW-1:0] w_wdata_calc;
  logic [DW-1:0] w_wdata;

  // Lane select uses the low address bits; for halfwords only addr[1] matters.
  function automatic logic [DW-1:0] f_load_extend(
    input logic [2:0]    op,
    input logic [DW-1:0] addr,
    input logic [DW-1:0] rdata
  );
    logic signed [7:0]  v_byte;
    logic signed [15:0] v_half;
    logic [DW-1:0]      v_out;
    v_byte = $signed(rdata[{addr[1:0], 3'b000} +: 8]);
    v_half = $signed(rdata[{addr[1], 4'b0000} +: 16]);
    case (op)
      LD_LB:   v_out = {{(DW-8){v_byte[7]}}, v_byte};
      LD_LBU:  v_out = {{(DW-8){1'b0}}, v_byte};
      LD_LH:   v_out = {{(DW-16){v_half[15]}}, v_half};
      LD_LHU:  v_out = {{(DW-16){1'b0}}, v_half};
      LD_LW:   v_out = rdata;
      LD_NONE: v_out = addr;
      default: v_out = addr;
    endcase
    return v_out;
  endfunction

  assign w_commit     = r_wb_valid && !r_done;
  assign w_wdata_calc = f_load_extend(r_wb_load_op, r_wb_result, bus.data_sram_rdata);
  // SRAM data is only guaranteed in the first WB cycle, so later cycles replay the hold copy.
  assign w_wdata      = w_commit ? w_wdata_calc : r_wdata_hold;

  // MEM/WB boundary
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wb_valid   <= 1'b0;
      r_wb_pc      <= '0;
      r_wb_we      <= 1'b0;
      r_wb_waddr   <= '0;
      r_wb_result  <= '0;
      r_wb_load_op <= LD_NONE;
      r_done       <= 1'b0;
      r_wdata_hold <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_done       <= 1'b1;
        r_wdata_hold <= w_wdata_calc;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      // Pipeline control is evaluated after the commit so its done<=0 takes priority.
      if (bus.flush) begin
        r_wb_valid <= 1'b0;
        r_done     <= 1'b0;
      end else if (!bus.stall) begin
        r_wb_valid   <= bus.mem_valid;
        r_wb_pc      <= bus.mem_pc;
        r_wb_we      <= bus.mem_we;
        r_wb_waddr   <= bus.mem_waddr;
        r_wb_result  <= bus.mem_result;
        r_wb_load_op <= bus.mem_load_op;
        r_done       <= 1'b0;
      end
    end
  end

  assign bus.rf_we      = w_commit && r_wb_we;
  assign bus.rf_waddr   = r_wb_waddr;
  assign bus.rf_wdata   = w_wdata;
  assign bus.fwd_valid  = r_wb_valid && r_wb_we;
  assign bus.fwd_waddr  = r_wb_waddr;
  assign bus.fwd_wdata  = w_wdata;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_pc      = r_wb_pc;
  assign bus.retire_cnt = r_retire_cnt;

`ifdef WB_TRACE_EN
  // Gated with resetn so the trace reads zero during the reset cycle itself.
  assign debug_wb_pc       = resetn ? r_wb_pc : 32'd0;
  assign debug_wb_rf_wen   = resetn ? {4{bus.rf_we}} : 4'd0;
  assign debug_wb_rf_wnum  = resetn ? 5'(r_wb_waddr) : 5'd0;
  assign debug_wb_rf_wdata = resetn ? 32'(w_wdata) : 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-extension table, directed stall/flush/reset/wrap
// sequences, and randomized traffic against a transaction-level reference model.
module tb_wb_stage;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  wb_stage_if #(.AW(5), .DW(32)) bus ();

`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_stage #(.AW(5), .DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: the instruction occupying WB and whether it has been written back.
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [2:0]  op;
  } instr_t;

  instr_t      m_instr;
  logic        m_written;
  logic [31:0] m_last_wdata;
  logic [31:0] m_retired;

  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] lane;
    logic [31:0] v;
    lane = addr % 32'd4;
    case (op)
      3'd1, 3'd2: begin
        v = (rdata >> (32'd8 * lane)) & 32'hFF;
        if (op == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (rdata >> (32'd16 * (lane / 32'd2))) & 32'hFFFF;
        if (op == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'd5:    v = rdata;
      default: v = addr;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic        first;
    logic [31:0] wd;
    first = m_instr.valid && !m_written;
    wd    = first ? ref_wdata(m_instr.op, m_instr.result, bus.data_sram_rdata) : m_last_wdata;
    chk({tag, ".rf_we"},      32'(bus.rf_we),     32'(first && m_instr.we));
    chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),  32'(m_instr.waddr));
    chk({tag, ".rf_wdata"},   bus.rf_wdata,       wd);
    chk({tag, ".fwd_valid"},  32'(bus.fwd_valid), 32'(m_instr.valid && m_instr.we));
    chk({tag, ".fwd_waddr"},  32'(bus.fwd_waddr), 32'(m_instr.waddr));
    chk({tag, ".fwd_wdata"},  bus.fwd_wdata,      wd);
    chk({tag, ".wb_valid"},   32'(bus.wb_valid),  32'(m_instr.valid));
    chk({tag, ".wb_pc"},      bus.wb_pc,          m_instr.pc);
    chk({tag, ".retire_cnt"}, bus.retire_cnt,     m_retired);
`ifdef WB_TRACE_EN
    chk({tag, ".dbg_wen"},   32'(debug_wb_rf_wen),   resetn ? {28'd0, {4{first && m_instr.we}}} : 32'd0);
    chk({tag, ".dbg_wdata"}, debug_wb_rf_wdata,      resetn ? wd : 32'd0);
`endif
  endtask

  task automatic model_step();
    logic first;
    first = m_instr.valid && !m_written;
    if (!resetn) begin
      m_instr      = '{default: '0};
      m_written    = 1'b0;
      m_last_wdata = 32'd0;
      m_retired    = 32'd0;
    end else begin
      if (first) begin
        m_written    = 1'b1;
        m_last_wdata = ref_wdata(m_instr.op, m_instr.result, bus.data_sram_rdata);
        m_retired    = m_retired + 32'd1;
      end
      if (bus.flush) begin
        m_instr.valid = 1'b0;
        m_written     = 1'b0;
      end else if (!bus.stall) begin
        m_instr.valid  = bus.mem_valid;
        m_instr.pc     = bus.mem_pc;
        m_instr.we     = bus.mem_we;
        m_instr.waddr  = bus.mem_waddr;
        m_instr.result = bus.mem_result;
        m_instr.op     = bus.mem_load_op;
        m_written      = 1'b0;
      end
    end
  endtask

  // Compare against the model, clock one edge, advance the model, return at negedge.
  task automatic tick(input string tag);
    #1 check_model(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_mem(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] wa, input logic [31:0] res, input logic [2:0] op);
    bus.mem_valid   = v;
    bus.mem_pc      = pc;
    bus.mem_we      = we;
    bus.mem_waddr   = wa;
    bus.mem_result  = res;
    bus.mem_load_op = op;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t   lvec [10];
  logic [31:0] base;

  initial begin
    n_vec = 0;
    n_err = 0;
    lvec[0] = '{3'd1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    lvec[1] = '{3'd2, 2'd1, 32'h80FF7F01, 32'h0000007F};
    lvec[2] = '{3'd3, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    lvec[3] = '{3'd4, 2'd0, 32'h80FF7F01, 32'h00007F01};
    lvec[4] = '{3'd5, 2'd0, 32'h80FF7F01, 32'h80FF7F01};
    lvec[5] = '{3'd1, 2'd0, 32'h80FF7F01, 32'h00000001};
    lvec[6] = '{3'd2, 2'd3, 32'h80FF7F01, 32'h00000080};
    lvec[7] = '{3'd3, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
    lvec[8] = '{3'd4, 2'd2, 32'h80FF7F01, 32'h000080FF};
    lvec[9] = '{3'd6, 2'd3, 32'h80FF7F01, 32'h00001003};

    resetn = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.data_sram_rdata = 32'd0;
    set_mem(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0);
    m_instr      = '{default: '0};
    m_written    = 1'b0;
    m_last_wdata = 32'd0;
    m_retired    = 32'd0;

    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    chk("reset.wb_valid",   32'(bus.wb_valid),  32'd0);
    chk("reset.rf_we",      32'(bus.rf_we),     32'd0);
    chk("reset.fwd_valid",  32'(bus.fwd_valid), 32'd0);
    chk("reset.wb_pc",      bus.wb_pc,          32'd0);
    chk("reset.rf_wdata",   bus.rf_wdata,       32'd0);
    chk("reset.retire_cnt", bus.retire_cnt,     32'd0);
    tick("reset");
    resetn = 1'b1;
    tick("release");

    // ALU write
    set_mem(1'b1, 32'h100, 1'b1, 5'd5, 32'h1234, 3'd0);
    tick("alu.in");
    bus.mem_valid = 1'b0;
    #1;
    chk("alu.rf_we",    32'(bus.rf_we),    32'd1);
    chk("alu.rf_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("alu.rf_wdata", bus.rf_wdata,      32'h1234);
    chk("alu.cnt0",     bus.retire_cnt,    32'd0);
    tick("alu.wb");
    #1;
    chk("alu.cnt1",     bus.retire_cnt,    32'd1);
    chk("alu.rf_we_off", 32'(bus.rf_we),   32'd0);

    // Load extraction table
    for (int i = 0; i < 10; i++) begin
      set_mem(1'b1, 32'h1000 + 32'(i) * 4, 1'b1, 5'd7, 32'h1000 + 32'(lvec[i].lo), lvec[i].op);
      bus.data_sram_rdata = 32'd0;
      tick("load.in");
      bus.mem_valid = 1'b0;
      bus.data_sram_rdata = lvec[i].rdata;
      #1;
      chk($sformatf("load%0d.rf_we", i),    32'(bus.rf_we), 32'd1);
      chk($sformatf("load%0d.rf_wdata", i), bus.rf_wdata,   lvec[i].exp);
      tick("load.wb");
    end

    // Stall for three edges while a load sits in WB
    set_mem(1'b1, 32'h200, 1'b1, 5'd9, 32'h2003, 3'd1);
    bus.data_sram_rdata = 32'd0;
    tick("stall.in");
    base = m_retired;
    bus.stall = 1'b1;
    set_mem(1'b1, 32'h300, 1'b1, 5'd10, 32'h5555, 3'd5);
    bus.data_sram_rdata = 32'h80FF7F01;
    #1;
    chk("stall.c1.rf_we",    32'(bus.rf_we), 32'd1);
    chk("stall.c1.rf_wdata", bus.rf_wdata,   32'hFFFFFF80);
    tick("stall.c1");
    bus.data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("stall.c2.rf_we",     32'(bus.rf_we),     32'd0);
    chk("stall.c2.fwd_valid", 32'(bus.fwd_valid), 32'd1);
    chk("stall.c2.fwd_wdata", bus.fwd_wdata,      32'hFFFFFF80);
    chk("stall.c2.wb_pc",     bus.wb_pc,          32'h200);
    chk("stall.c2.cnt",       bus.retire_cnt,     base + 32'd1);
    tick("stall.c2");
    #1;
    chk("stall.c3.rf_we",     32'(bus.rf_we), 32'd0);
    chk("stall.c3.fwd_wdata", bus.fwd_wdata,  32'hFFFFFF80);
    tick("stall.c3");
    bus.stall = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("stall.c4.rf_we", 32'(bus.rf_we),  32'd0);
    chk("stall.c4.cnt",   bus.retire_cnt,  base + 32'd1);
    tick("stall.c4");

    // Flush overrides stall
    base = m_retired;
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    set_mem(1'b1, 32'h400, 1'b1, 5'd3, 32'h77, 3'd0);
    tick("flush.in");
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("flush.wb_valid",  32'(bus.wb_valid),  32'd0);
    chk("flush.rf_we",     32'(bus.rf_we),     32'd0);
    chk("flush.fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("flush.cnt",       bus.retire_cnt,     base);
    tick("flush.after");

    // Reset mid-stream with a valid instruction in WB
    set_mem(1'b1, 32'h500, 1'b1, 5'd4, 32'hABCD, 3'd0);
    tick("rst.in");
    bus.mem_valid = 1'b0;
    resetn = 1'b0;
    tick("rst.low");
    resetn = 1'b1;
    #1;
    chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst.rf_we",    32'(bus.rf_we),    32'd0);
    chk("rst.wb_pc",    bus.wb_pc,         32'd0);
    chk("rst.rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst.rf_wdata", bus.rf_wdata,      32'd0);
    chk("rst.cnt",      bus.retire_cnt,    32'd0);
    set_mem(1'b1, 32'h600, 1'b1, 5'd6, 32'h42, 3'd0);
    tick("rst.resume");
    bus.mem_valid = 1'b0;
    #1;
    chk("rst.resume.rf_we",    32'(bus.rf_we), 32'd1);
    chk("rst.resume.rf_wdata", bus.rf_wdata,   32'h42);
    tick("rst.resume.wb");
    #1;
    chk("rst.resume.cnt", bus.retire_cnt, 32'd1);

    // Counter wrap
    force dut.r_retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_retire_cnt;
    m_retired = 32'hFFFFFFFF;
    #1;
    chk("wrap.preload", bus.retire_cnt, 32'hFFFFFFFF);
    set_mem(1'b1, 32'h700, 1'b1, 5'd8, 32'h1, 3'd0);
    tick("wrap.in");
    bus.mem_valid = 1'b0;
    tick("wrap.wb");
    #1;
    chk("wrap.cnt", bus.retire_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      resetn    = ($urandom_range(0, 63) != 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      set_mem(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom),
              $urandom, 3'($urandom_range(0, 7)));
      bus.data_sram_rdata = $urandom;
      tick("rand");
    end
    resetn = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.mem_valid = 1'b0;
    tick("drain");
    tick("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
